clk_div_multi: RTL and testbench



---
 rtl/clk_div_multi_if.sv | 48 ++++
 rtl/clk_div_multi.sv | 169 ++++++++++++++++
 tb/tb_clk_div_multi.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if
//   Bundles the control, configuration and output signals of the
//   multi-channel clock/tick divider.
//
//   Signals:
//     en       per-channel run enable
//     sync_clr synchronous realign of every channel
//     cfg_we   configuration write strobe (one cycle)
//     cfg_ch   channel addressed by the write
//     cfg_div  new period in clk cycles
//     cfg_high new high-time in clk cycles
//     out      per-channel divided level
//     tick     one-cycle pulse at each period end
//     busy     per-channel "new config waiting for period boundary"
//
//   Handshake: there is no valid/ready pair. cfg_we is a strobe that is
//   always accepted in the cycle it is high; busy only reports that the
//   accepted values are still waiting for the channel's period boundary
//   and never back-pressures the writer.
//
//   Modports: master drives control/config and observes outputs;
//   slave is the divider itself.

interface clk_div_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0] en;
    logic              sync_clr;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [CNT_W-1:0]  cfg_high;
    logic [NUM_CH-1:0] out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] busy;

    modport master (
        output en, sync_clr, cfg_we, cfg_ch, cfg_div, cfg_high,
        input  out, tick, busy
    );

    modport slave (
        input  en, sync_clr, cfg_we, cfg_ch, cfg_div, cfg_high,
        output out, tick, busy
    );
endinterface

// File: rtl/clk_div_multi.sv
// clk_div_multi
//   Multi-channel, run-time programmable clock/tick divider. Each channel
//   counts 0..A-1 (A = active period) and produces a registered level
//   out = (cnt < HA) and a registered one-cycle tick on the last count.
//   New settings written while a channel runs are held in a shadow and
//   only take effect at that channel's period boundary, so the output
//   never glitches mid-period.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    clk_div_multi_if.slave (en, sync_clr, cfg_*, out, tick, busy)
//
//   Parameters:
//     NUM_CH      number of channels (1..16)
//     CNT_W       counter / period / high-time width
//     DEFAULT_DIV reset period of every channel (< 2**CNT_W)

module clk_div_multi #(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 50_000_000
) (
    input logic             clk,
    input logic             rst_n,
    clk_div_multi_if.slave  bus
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEF_HIGH = CNT_W'(DEFAULT_DIV / 2);

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  a_q     [NUM_CH];   // active period
    logic [CNT_W-1:0]  ha_q    [NUM_CH];   // active high-time
    logic [CNT_W-1:0]  sdiv_q  [NUM_CH];   // shadow period
    logic [CNT_W-1:0]  shigh_q [NUM_CH];   // shadow high-time
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] out_q;
    logic [NUM_CH-1:0] tick_q;

    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [CNT_W-1:0]  a_d     [NUM_CH];
    logic [CNT_W-1:0]  ha_d    [NUM_CH];
    logic [CNT_W-1:0]  sdiv_d  [NUM_CH];
    logic [CNT_W-1:0]  shigh_d [NUM_CH];
    logic [NUM_CH-1:0] pend_d;
    logic [NUM_CH-1:0] out_d;
    logic [NUM_CH-1:0] tick_d;

    // ------------------------------------------------------------------
    // Per-channel qualifiers
    //   wr_hit : this channel is addressed by the current write. A cfg_ch
    //            value >= NUM_CH matches no channel, so such writes are
    //            dropped without a separate range check.
    //   run    : channel counts this cycle (enabled, not halted, no clear)
    //   wrap   : channel is on its last count of the period
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] run;
    logic [NUM_CH-1:0] wrap;

    always_comb begin
        wr_hit = '0;
        run    = '0;
        wrap   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_hit[c] = bus.cfg_we && (bus.cfg_ch == CH_W'(c));
            run[c]    = bus.en[c] && (a_q[c] != '0) && !bus.sync_clr;
            // a_q != 0 whenever run is set, so a_q-1 cannot underflow here
            wrap[c]   = run[c] && (cnt_q[c] == (a_q[c] - CNT_W'(1)));
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        ha_d    = ha_q;
        sdiv_d  = sdiv_q;
        shigh_d = shigh_q;
        pend_d  = pend_q;
        out_d   = '0;
        tick_d  = '0;

        for (int c = 0; c < NUM_CH; c++) begin
            if (!run[c]) begin
                // Disabled, halted or being realigned: park the counter
                // at zero with both outputs low. Nothing is mid-period,
                // so settings can switch over right now. A coincident
                // write is newer than any shadow and wins.
                cnt_d[c] = '0;
                if (wr_hit[c]) begin
                    a_d[c]  = bus.cfg_div;
                    ha_d[c] = bus.cfg_high;
                end else if (pend_q[c]) begin
                    a_d[c]  = sdiv_q[c];
                    ha_d[c] = shigh_q[c];
                end
                pend_d[c] = 1'b0;
            end else begin
                // Outputs always reflect the settings of the period that
                // is finishing, including the wrap tick itself.
                out_d[c]  = (cnt_q[c] < ha_q[c]);
                tick_d[c] = wrap[c];

                if (wrap[c]) begin
                    cnt_d[c] = '0;
                    if (wr_hit[c]) begin
                        a_d[c]  = bus.cfg_div;
                        ha_d[c] = bus.cfg_high;
                    end else if (pend_q[c]) begin
                        a_d[c]  = sdiv_q[c];
                        ha_d[c] = shigh_q[c];
                    end
                    pend_d[c] = 1'b0;
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                    if (wr_hit[c]) begin
                        // Last write before the boundary wins.
                        sdiv_d[c]  = bus.cfg_div;
                        shigh_d[c] = bus.cfg_high;
                        pend_d[c]  = 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c]   <= '0;
                a_q[c]     <= DEF_DIV;
                ha_q[c]    <= DEF_HIGH;
                sdiv_q[c]  <= '0;
                shigh_q[c] <= '0;
            end
            pend_q <= '0;
            out_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c]   <= cnt_d[c];
                a_q[c]     <= a_d[c];
                ha_q[c]    <= ha_d[c];
                sdiv_q[c]  <= sdiv_d[c];
                shigh_q[c] <= shigh_d[c];
            end
            pend_q <= pend_d;
            out_q  <= out_d;
            tick_q <= tick_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.tick = tick_q;
    assign bus.busy = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi
//   Bench for clk_div_multi with two channels, 8-bit counters and a reset
//   period of 4. A cycle-level reference model pushes the expected
//   {busy, tick, out} word every cycle; it is compared after the edge.
//   Directed pattern checks from literal constants back up the model.

module tb_clk_div_multi;

    localparam int NUM_CH      = 2;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 4;
    localparam int CH_W        = 1;
    localparam int W           = 3 * NUM_CH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    clk_div_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc_n = 0;

    logic [NUM_CH-1:0] last_out, last_tick, last_busy;
    logic [15:0]       cap_out  [NUM_CH];
    logic [15:0]       cap_tick [NUM_CH];
    logic [15:0]       cap_busy [NUM_CH];

    // ---------------- reference model ----------------
    logic [CNT_W-1:0]  m_cnt [NUM_CH];
    logic [CNT_W-1:0]  m_a   [NUM_CH];
    logic [CNT_W-1:0]  m_ha  [NUM_CH];
    logic [CNT_W-1:0]  m_sa  [NUM_CH];
    logic [CNT_W-1:0]  m_sh  [NUM_CH];
    logic [NUM_CH-1:0] m_pend, m_out, m_tick;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = '0;
            m_a[c]   = CNT_W'(DEFAULT_DIV);
            m_ha[c]  = CNT_W'(DEFAULT_DIV / 2);
            m_sa[c]  = '0;
            m_sh[c]  = '0;
        end
        m_pend = '0;
        m_out  = '0;
        m_tick = '0;
    endtask

    // Advance the model by one clock edge using the inputs now on the bus.
    task automatic model_step();
        logic hit, last;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            hit = bus.cfg_we && (bus.cfg_ch == CH_W'(c));
            if (bus.sync_clr || !bus.en[c] || m_a[c] == 0) begin
                m_cnt[c]  = '0;
                m_out[c]  = 1'b0;
                m_tick[c] = 1'b0;
                if (hit) begin
                    m_a[c] = bus.cfg_div; m_ha[c] = bus.cfg_high;
                end else if (m_pend[c]) begin
                    m_a[c] = m_sa[c]; m_ha[c] = m_sh[c];
                end
                m_pend[c] = 1'b0;
            end else begin
                last      = (m_cnt[c] == m_a[c] - 8'd1);
                m_out[c]  = (m_cnt[c] < m_ha[c]);
                m_tick[c] = last;
                if (last) begin
                    m_cnt[c] = '0;
                    if (hit) begin
                        m_a[c] = bus.cfg_div; m_ha[c] = bus.cfg_high;
                    end else if (m_pend[c]) begin
                        m_a[c] = m_sa[c]; m_ha[c] = m_sh[c];
                    end
                    m_pend[c] = 1'b0;
                end else begin
                    m_cnt[c] = m_cnt[c] + 8'd1;
                    if (hit) begin
                        m_sa[c] = bus.cfg_div; m_sh[c] = bus.cfg_high;
                        m_pend[c] = 1'b1;
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge with inputs already set; returns at the
    // next falling edge.
    task automatic cycle();
        logic [W-1:0] got;
        logic [W-1:0] exp;
        model_step();
        exp_q.push_back({m_pend, m_tick, m_out});
        @(posedge clk);
        #1;
        cyc_n++;
        last_out  = bus.out;
        last_tick = bus.tick;
        last_busy = bus.busy;
        got = {bus.busy, bus.tick, bus.out};
        exp = exp_q.pop_front();
        check_eq($sformatf("cyc%0d", cyc_n), 32'(got), 32'(exp));
        @(negedge clk);
    endtask

    task automatic cfg_write(input int ch, input int div, input int high);
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = CH_W'(ch);
        bus.cfg_div  = CNT_W'(div);
        bus.cfg_high = CNT_W'(high);
        cycle();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int c = 0; c < NUM_CH; c++) begin
            cap_out[c] = '0; cap_tick[c] = '0; cap_busy[c] = '0;
        end
        for (int i = 0; i < n; i++) begin
            cycle();
            for (int c = 0; c < NUM_CH; c++) begin
                cap_out[c]  = {cap_out[c][14:0],  last_out[c]};
                cap_tick[c] = {cap_tick[c][14:0], last_tick[c]};
                cap_busy[c] = {cap_busy[c][14:0], last_busy[c]};
            end
        end
    endtask

    task automatic wait_tick(input int ch, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n++;
            if (last_tick[ch]) break;
        end
        check_eq($sformatf("wait_tick%0d", ch), 32'(last_tick[ch]), 32'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_n        = 1'b0;
        bus.en       = '0;
        bus.sync_clr = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_ch   = '0;
        bus.cfg_div  = '0;
        bus.cfg_high = '0;
        model_reset();

        repeat (2) @(negedge clk);
        check_eq("rst_out",  32'(bus.out),  32'd0);
        check_eq("rst_tick", 32'(bus.tick), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);

        // Test 1: default period 4, high 2 on both channels.
        bus.en = 2'b11;
        cycle();
        rst_n = 1'b1;
        capture(8);
        check_eq("t1_out0",  32'(cap_out[0][7:0]),  32'b11001100);
        check_eq("t1_tick0", 32'(cap_tick[0][7:0]), 32'b00010001);
        check_eq("t1_out1",  32'(cap_out[1][7:0]),  32'b11001100);
        check_eq("t1_tick1", 32'(cap_tick[1][7:0]), 32'b00010001);

        // Test 2: mid-period rewrite of ch0 to N=6, H=1.
        cycle();
        cfg_write(0, 6, 1);
        check_eq("t2_busy_set", 32'(last_busy[0]), 32'd1);
        wait_tick(0, n);
        check_eq("t2_old_len",  32'(n), 32'd2);
        check_eq("t2_busy_clr", 32'(last_busy[0]), 32'd0);
        capture(6);
        check_eq("t2_out0",  32'(cap_out[0][5:0]),  32'b100000);
        check_eq("t2_tick0", 32'(cap_tick[0][5:0]), 32'b000001);

        // Test 3: write ch1 exactly on its wrap cycle.
        wait_tick(1, n);
        repeat (3) cycle();
        cfg_write(1, 3, 3);
        check_eq("t3_no_busy",  32'(last_busy[1]), 32'd0);
        check_eq("t3_wrap_tck", 32'(last_tick[1]), 32'd1);
        capture(6);
        check_eq("t3_out1",  32'(cap_out[1][5:0]),  32'b111111);
        check_eq("t3_tick1", 32'(cap_tick[1][5:0]), 32'b001001);

        // Test 4: halt ch0 with N=0, then restart directly with N=2, H=1.
        wait_tick(0, n);
        cycle();
        cfg_write(0, 0, 3);
        check_eq("t4_busy_set", 32'(last_busy[0]), 32'd1);
        wait_tick(0, n);
        check_eq("t4_old_len", 32'(n), 32'd4);
        capture(8);
        check_eq("t4_halt_out",  32'(cap_out[0][7:0]),  32'd0);
        check_eq("t4_halt_tick", 32'(cap_tick[0][7:0]), 32'd0);
        check_eq("t4_halt_busy", 32'(cap_busy[0][7:0]), 32'd0);
        cfg_write(0, 2, 1);
        check_eq("t4_direct", 32'(last_busy[0]), 32'd0);
        capture(4);
        check_eq("t4_out0",  32'(cap_out[0][3:0]),  32'b1010);
        check_eq("t4_tick0", 32'(cap_tick[0][3:0]), 32'b0101);

        // Test 5: N=5 / N=3 drift apart, then realign with sync_clr.
        cfg_write(0, 5, 2);
        cfg_write(1, 3, 1);
        repeat (7) cycle();
        bus.sync_clr = 1'b1;
        cycle();
        bus.sync_clr = 1'b0;
        check_eq("t5_clr_out",  32'(last_out),  32'd0);
        check_eq("t5_clr_tick", 32'(last_tick), 32'd0);
        capture(5);
        check_eq("t5_out0",  32'(cap_out[0][4:0]),  32'b11000);
        check_eq("t5_tick0", 32'(cap_tick[0][4:0]), 32'b00001);
        check_eq("t5_out1",  32'(cap_out[1][4:0]),  32'b10010);
        check_eq("t5_tick1", 32'(cap_tick[1][4:0]), 32'b00100);

        // Test 7: disabling a channel applies its pending shadow at once.
        cycle();
        cfg_write(1, 4, 4);
        check_eq("t7_busy_set", 32'(last_busy[1]), 32'd1);
        bus.en = 2'b01;
        cycle();
        check_eq("t7_busy_clr", 32'(last_busy[1]), 32'd0);
        check_eq("t7_dis_out",  32'(last_out[1]),  32'd0);
        bus.en = 2'b11;
        capture(4);
        check_eq("t7_out1",  32'(cap_out[1][3:0]),  32'b1111);
        check_eq("t7_tick1", 32'(cap_tick[1][3:0]), 32'b0001);

        // Test 6: asynchronous reset mid-period drops a pending write.
        wait_tick(0, n);
        cycle();
        cfg_write(0, 9, 1);
        check_eq("t6_pend", 32'(last_busy[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_out",  32'(bus.out),  32'd0);
        check_eq("t6_rst_tick", 32'(bus.tick), 32'd0);
        check_eq("t6_rst_busy", 32'(bus.busy), 32'd0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        capture(8);
        check_eq("t6_out0",  32'(cap_out[0][7:0]),  32'b11001100);
        check_eq("t6_tick0", 32'(cap_tick[0][7:0]), 32'b00010001);
        check_eq("t6_out1",  32'(cap_out[1][7:0]),  32'b11001100);
        check_eq("t6_tick1", 32'(cap_tick[1][7:0]), 32'b00010001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
